// File: rtl/sound_mailbox_if.sv
// sound_mailbox_if: bus bundle between the 68k/Z80 decode logic and the sound mailbox.
// The master modport drives the bus inputs and the slave modport drives the mailbox outputs.
interface sound_mailbox_if;
    // 68k side
    logic       m68k_sound_latch_cs;
    logic       m68k_rw;
    logic       m68k_lds_n;
    logic [7:0] m68k_wdata;
    // Z80 side
    logic       z80_clk_en;
    logic       z80_latch_r_cs;
    logic       z80_latch_clr_cs;
    logic       z80_rd_n;
    logic       z80_m1_n;
    logic       z80_iorq_n;
    // Mailbox outputs
    logic [7:0] z80_latch_dout;
    logic       latch_pending;
    logic       latch_overflow;
    logic       z80_int_n;

    modport master (
        output m68k_sound_latch_cs, m68k_rw, m68k_lds_n, m68k_wdata,
        output z80_clk_en, z80_latch_r_cs, z80_latch_clr_cs, z80_rd_n, z80_m1_n, z80_iorq_n,
        input  z80_latch_dout, latch_pending, latch_overflow, z80_int_n
    );

    modport slave (
        input  m68k_sound_latch_cs, m68k_rw, m68k_lds_n, m68k_wdata,
        input  z80_clk_en, z80_latch_r_cs, z80_latch_clr_cs, z80_rd_n, z80_m1_n, z80_iorq_n,
        output z80_latch_dout, latch_pending, latch_overflow, z80_int_n
    );
endinterface

// File: rtl/sound_mailbox.sv
// sound_mailbox: 68k->Z80 sound command latch plus the Z80 periodic interrupt.
// Define SOUND_MAILBOX_FIFO_EN to replace the single command register with a 4-entry FIFO.
// All outputs are registered; bus events go through registered edge detectors first.
module sound_mailbox #(
    parameter int unsigned IRQ_DIV = 512
) (
    input logic            clk_sys,
    input logic            reset_n,
    sound_mailbox_if.slave bus
);

    logic wr_act, rd_act, int_ack;
    assign wr_act  = bus.m68k_sound_latch_cs & ~bus.m68k_rw & ~bus.m68k_lds_n;
    assign rd_act  = bus.z80_latch_r_cs & ~bus.z80_rd_n;
    assign int_ack = ~bus.z80_m1_n & ~bus.z80_iorq_n;

    // Previous-value registers reset to 1 so a level still held after reset is not an edge.
    logic       wr_prev_q, rd_prev_q, clr_prev_q;
    logic       push_q, pop_q, clr_q;
    logic [7:0] push_data_q;

    // Edge detection: one-cycle action pulses, write data captured with the push pulse.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_prev_q   <= 1'b1;
            rd_prev_q   <= 1'b1;
            clr_prev_q  <= 1'b1;
            push_q      <= 1'b0;
            pop_q       <= 1'b0;
            clr_q       <= 1'b0;
            push_data_q <= 8'h00;
        end else begin
            wr_prev_q  <= wr_act;
            rd_prev_q  <= rd_act;
            clr_prev_q <= bus.z80_latch_clr_cs;
            push_q     <= wr_act & ~wr_prev_q;
            pop_q      <= ~rd_act & rd_prev_q;
            clr_q      <= bus.z80_latch_clr_cs & ~clr_prev_q;
            if (wr_act && !wr_prev_q) begin
                push_data_q <= bus.m68k_wdata;
            end
        end
    end

    logic [7:0] dout_q;
    logic       pending_q, overflow_q;

`ifdef SOUND_MAILBOX_FIFO_EN
    logic [7:0] mem_q [4];
    logic [7:0] mem_d [4];
    logic [1:0] rd_ptr_q, rd_ptr_d, wr_idx;
    logic [2:0] count_q, count_d;
    logic       overflow_d, do_push, do_pop;
    logic [7:0] dout_d;

    // Next FIFO state: clear is applied before push; a pop frees a slot for a same-cycle push.
    always_comb begin
        mem_d      = mem_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        do_pop     = pop_q && (count_q != 3'd0);
        do_push    = push_q && ((count_q != 3'd4) || do_pop);
        wr_idx     = rd_ptr_q + count_q[1:0];
        if (clr_q) begin
            rd_ptr_d   = 2'd0;
            overflow_d = 1'b0;
            count_d    = {2'b00, push_q};
            if (push_q) begin
                mem_d[0] = push_data_q;
            end
        end else begin
            if (push_q && !do_push) begin
                overflow_d = 1'b1;
            end
            if (do_push) begin
                mem_d[wr_idx] = push_data_q;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 2'd1;
            end
            count_d = count_q + {2'b00, do_push} - {2'b00, do_pop};
        end
        dout_d = (count_d == 3'd0) ? 8'h00 : mem_d[rd_ptr_d];
    end

    // FIFO state and registered outputs.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= 8'h00;
            end
            rd_ptr_q   <= 2'd0;
            count_q    <= 3'd0;
            overflow_q <= 1'b0;
            pending_q  <= 1'b0;
            dout_q     <= 8'h00;
        end else begin
            mem_q      <= mem_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            pending_q  <= (count_d != 3'd0);
            dout_q     <= dout_d;
        end
    end
`else
    // Reads leave the single register untouched.
    logic unused_pop;
    assign unused_pop = pop_q;

    // Single command register: clear first, then push; a push over a pending byte overflows.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dout_q     <= 8'h00;
            pending_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (clr_q) begin
                pending_q  <= push_q;
                overflow_q <= 1'b0;
            end else if (push_q) begin
                pending_q  <= 1'b1;
                overflow_q <= overflow_q | pending_q;
            end
            if (push_q) begin
                dout_q <= push_data_q;
            end
        end
    end
`endif

    logic [15:0] irq_cnt_q;
    logic        irq_wrap;
    logic        int_n_q;
    assign irq_wrap = bus.z80_clk_en && (irq_cnt_q == 16'(IRQ_DIV - 1));

    // IRQ timer: request set at wrap, held until M1+IORQ acknowledge; a wrap wins over an ack.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            irq_cnt_q <= 16'd0;
            int_n_q   <= 1'b1;
        end else begin
            if (bus.z80_clk_en) begin
                irq_cnt_q <= irq_wrap ? 16'd0 : irq_cnt_q + 16'd1;
            end
            if (irq_wrap) begin
                int_n_q <= 1'b0;
            end else if (int_ack) begin
                int_n_q <= 1'b1;
            end
        end
    end

    assign bus.z80_latch_dout = dout_q;
    assign bus.latch_pending  = pending_q;
    assign bus.latch_overflow = overflow_q;
    assign bus.z80_int_n      = int_n_q;

endmodule

// File: tb/tb_sound_mailbox.sv
// tb_sound_mailbox: directed checks of the sound mailbox latch, clear, IRQ timer and reset.
module tb_sound_mailbox;

    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp   = 0;
    int   n_err   = 0;

    sound_mailbox_if bus ();

    sound_mailbox #(.IRQ_DIV(4)) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic step();
        @(posedge clk_sys);
        @(negedge clk_sys);
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr_set(input logic [7:0] d);
        bus.m68k_sound_latch_cs = 1'b1;
        bus.m68k_rw             = 1'b0;
        bus.m68k_lds_n          = 1'b0;
        bus.m68k_wdata          = d;
    endtask

    task automatic wr_drop();
        bus.m68k_sound_latch_cs = 1'b0;
        bus.m68k_rw             = 1'b1;
        bus.m68k_lds_n          = 1'b1;
    endtask

    task automatic wr_cmd(input logic [7:0] d);
        wr_set(d);
        step();
        step();
        wr_drop();
        step();
        step();
    endtask

    task automatic clr_cmd();
        bus.z80_latch_clr_cs = 1'b1;
        step();
        bus.z80_latch_clr_cs = 1'b0;
        step();
        step();
    endtask

    task automatic rd_byte(input string tag, input logic [7:0] exp);
        bus.z80_latch_r_cs = 1'b1;
        bus.z80_rd_n       = 1'b0;
        step();
        check(tag, {8'h00, bus.z80_latch_dout}, {8'h00, exp});
        bus.z80_latch_r_cs = 1'b0;
        bus.z80_rd_n       = 1'b1;
        step();
        step();
    endtask

    logic [7:0] exp_clr_dout;

    initial begin
        wr_drop();
        bus.m68k_wdata       = 8'h00;
        bus.z80_clk_en       = 1'b1;
        bus.z80_latch_r_cs   = 1'b0;
        bus.z80_latch_clr_cs = 1'b0;
        bus.z80_rd_n         = 1'b1;
        bus.z80_m1_n         = 1'b1;
        bus.z80_iorq_n       = 1'b1;
`ifdef SOUND_MAILBOX_FIFO_EN
        exp_clr_dout = 8'h00;
`else
        exp_clr_dout = 8'h5A;
`endif

        // Reset values
        step();
        step();
        check("rst_dout", {8'h00, bus.z80_latch_dout}, 16'h0000);
        check("rst_pending", {15'd0, bus.latch_pending}, 16'd0);
        check("rst_overflow", {15'd0, bus.latch_overflow}, 16'd0);
        check("rst_int_n", {15'd0, bus.z80_int_n}, 16'd1);

        // IRQ timer, IRQ_DIV=4, tick every cycle
        reset_n = 1'b1;
        step();
        step();
        step();
        check("irq_before_first", {15'd0, bus.z80_int_n}, 16'd1);
        step();
        check("irq_first", {15'd0, bus.z80_int_n}, 16'd0);
        bus.z80_m1_n   = 1'b0;
        bus.z80_iorq_n = 1'b0;
        step();
        check("irq_ack", {15'd0, bus.z80_int_n}, 16'd1);
        bus.z80_m1_n   = 1'b1;
        bus.z80_iorq_n = 1'b1;
        step();
        step();
        check("irq_before_second", {15'd0, bus.z80_int_n}, 16'd1);
        step();
        check("irq_second", {15'd0, bus.z80_int_n}, 16'd0);
        step();
        step();
        step();
        bus.z80_m1_n   = 1'b0;
        bus.z80_iorq_n = 1'b0;
        step();
        check("irq_ack_with_tick", {15'd0, bus.z80_int_n}, 16'd0);
        bus.z80_m1_n   = 1'b1;
        bus.z80_iorq_n = 1'b1;
        bus.z80_clk_en = 1'b0;
        step();
        check("irq_no_tick_holds", {15'd0, bus.z80_int_n}, 16'd0);

        // Basic write held 8 cycles
        wr_set(8'h5A);
        step();
        check("wr_pending_1cyc", {15'd0, bus.latch_pending}, 16'd0);
        step();
        check("wr_pending_2cyc", {15'd0, bus.latch_pending}, 16'd1);
        check("wr_dout", {8'h00, bus.z80_latch_dout}, 16'h005A);
        repeat (6) step();
        wr_drop();
        step();
        step();
        check("wr_single_push", {15'd0, bus.latch_overflow}, 16'd0);
        check("wr_pending_held", {15'd0, bus.latch_pending}, 16'd1);

        clr_cmd();
        check("clr_pending", {15'd0, bus.latch_pending}, 16'd0);
        check("clr_dout", {8'h00, bus.z80_latch_dout}, {8'h00, exp_clr_dout});

`ifdef SOUND_MAILBOX_FIFO_EN
        // FIFO fill past capacity, then drain
        for (int i = 1; i <= 5; i++) begin
            wr_cmd(8'(i));
        end
        check("fifo_overflow", {15'd0, bus.latch_overflow}, 16'd1);
        check("fifo_pending", {15'd0, bus.latch_pending}, 16'd1);
        rd_byte("fifo_rd1", 8'h01);
        rd_byte("fifo_rd2", 8'h02);
        rd_byte("fifo_rd3", 8'h03);
        rd_byte("fifo_rd4", 8'h04);
        check("fifo_empty_dout", {8'h00, bus.z80_latch_dout}, 16'h0000);
        check("fifo_empty_pending", {15'd0, bus.latch_pending}, 16'd0);
        clr_cmd();
        check("fifo_clr_overflow", {15'd0, bus.latch_overflow}, 16'd0);
`else
        // Clear and overwrite
        wr_cmd(8'h11);
        check("ow_first_ovf", {15'd0, bus.latch_overflow}, 16'd0);
        clr_cmd();
        check("ow_clr_pending", {15'd0, bus.latch_pending}, 16'd0);
        check("ow_clr_dout", {8'h00, bus.z80_latch_dout}, 16'h0011);
        wr_cmd(8'h22);
        wr_cmd(8'h33);
        check("ow_dout", {8'h00, bus.z80_latch_dout}, 16'h0033);
        check("ow_overflow", {15'd0, bus.latch_overflow}, 16'd1);
        rd_byte("ow_read", 8'h33);
        check("ow_read_no_change", {15'd0, bus.latch_pending}, 16'd1);
        clr_cmd();
        check("ow_clr_overflow", {15'd0, bus.latch_overflow}, 16'd0);
        check("ow_clr_pending2", {15'd0, bus.latch_pending}, 16'd0);
        check("ow_clr_dout2", {8'h00, bus.z80_latch_dout}, 16'h0033);
`endif

        // Same-cycle push and clear with a byte already pending
        wr_cmd(8'h44);
        wr_set(8'h55);
        bus.z80_latch_clr_cs = 1'b1;
        step();
        step();
        check("pc_pending", {15'd0, bus.latch_pending}, 16'd1);
        check("pc_overflow", {15'd0, bus.latch_overflow}, 16'd0);
        check("pc_dout", {8'h00, bus.z80_latch_dout}, 16'h0055);
        wr_drop();
        bus.z80_latch_clr_cs = 1'b0;
        step();
        step();

        // Reset while a write is held
        wr_set(8'h77);
        step();
        step();
        check("rw_pushed", {8'h00, bus.z80_latch_dout}, 16'h0077);
        reset_n = 1'b0;
        #1;
        check("rw_rst_dout", {8'h00, bus.z80_latch_dout}, 16'h0000);
        check("rw_rst_pending", {15'd0, bus.latch_pending}, 16'd0);
        check("rw_rst_overflow", {15'd0, bus.latch_overflow}, 16'd0);
        check("rw_rst_int_n", {15'd0, bus.z80_int_n}, 16'd1);
        @(negedge clk_sys);
        step();
        reset_n = 1'b1;
        repeat (4) step();
        check("rw_no_push_pending", {15'd0, bus.latch_pending}, 16'd0);
        check("rw_no_push_dout", {8'h00, bus.z80_latch_dout}, 16'h0000);
        wr_drop();
        step();
        wr_set(8'h66);
        step();
        step();
        check("rw_repush_pending", {15'd0, bus.latch_pending}, 16'd1);
        check("rw_repush_dout", {8'h00, bus.z80_latch_dout}, 16'h0066);
        wr_drop();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
